// File: rtl/bram_sp_req_adapter.sv
// Valid/ready request front-end for a single-port byte-masked BRAM, with a small read-response FIFO.
// Build macro BRAM_SP_REQ_ADAPTER_WRACK_EN: writes also return one zero-data response beat each.
module bram_sp_req_adapter #(
  parameter  int DATA_WIDTH = 32,
  parameter  int BRAM_DEPTH = 128,
  parameter  int RSP_DEPTH  = 2,
  localparam int ADDR_WIDTH = $clog2(BRAM_DEPTH),
  localparam int MASK_WIDTH = DATA_WIDTH / 8
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  req_valid_i,
  output logic                  req_ready_o,
  input  logic                  req_we_i,
  input  logic [ADDR_WIDTH-1:0] req_addr_i,
  input  logic [DATA_WIDTH-1:0] req_data_i,
  input  logic [MASK_WIDTH-1:0] req_mask_i,
  output logic                  rsp_valid_o,
  input  logic                  rsp_ready_i,
  output logic [DATA_WIDTH-1:0] rsp_data_o,
  output logic [DATA_WIDTH-1:0] bram_data_o,
  output logic [ADDR_WIDTH-1:0] bram_addr_o,
  output logic [MASK_WIDTH-1:0] bram_mask_o,
  output logic                  bram_wr_en_o,
  output logic                  bram_cmd_en_o,
  input  logic [DATA_WIDTH-1:0] bram_data_i
);

  localparam int PTR_W = $clog2(RSP_DEPTH);
  localparam int CNT_W = $clog2(RSP_DEPTH + 1);
  localparam logic [CNT_W:0]   CREDIT_MAX = (CNT_W + 1)'(RSP_DEPTH);
  localparam logic [CNT_W-1:0] OCC_FULL   = CNT_W'(RSP_DEPTH);

  logic [CNT_W-1:0]      occ_r;
  logic                  rd_inflight_r;
  logic [PTR_W-1:0]      head_r;
  logic [PTR_W-1:0]      tail_r;
  logic [DATA_WIDTH-1:0] rsp_mem_r [RSP_DEPTH];

  logic [CNT_W:0]        credit_s;
  logic                  fire_s;
  logic                  alloc_s;
  logic                  capture_s;
  logic                  pop_s;
  logic [CNT_W-1:0]      occ_next_s;
  logic [DATA_WIDTH-1:0] capture_data_s;

`ifdef BRAM_SP_REQ_ADAPTER_WRACK_EN
  logic                  wr_inflight_r;
`endif

  // Credit check: queued plus in-flight responses must leave room for one more capture.
  // Ready looks only at registered state, so full-rate streaming needs RSP_DEPTH >= 3.
  always_comb begin
    credit_s    = {1'b0, occ_r} + {{CNT_W{1'b0}}, rd_inflight_r};
    req_ready_o = rst_ni & (credit_s < CREDIT_MAX);
  end

  assign fire_s        = req_valid_i & req_ready_o;
  assign bram_cmd_en_o = fire_s;
  assign bram_wr_en_o  = req_we_i;
  assign bram_addr_o   = req_addr_i;
  assign bram_data_o   = req_data_i;
  assign bram_mask_o   = req_mask_i;

`ifdef BRAM_SP_REQ_ADAPTER_WRACK_EN
  assign alloc_s = fire_s;
`else
  assign alloc_s = fire_s & ~req_we_i;
`endif

  assign capture_s   = rd_inflight_r;
  assign rsp_valid_o = (occ_r != {CNT_W{1'b0}});
  assign pop_s       = rsp_valid_o & rsp_ready_i;
  assign rsp_data_o  = rsp_mem_r[head_r];

  // Select the beat captured this cycle; write acknowledgements carry zero data.
  always_comb begin
    capture_data_s = bram_data_i;
`ifdef BRAM_SP_REQ_ADAPTER_WRACK_EN
    if (wr_inflight_r) begin
      capture_data_s = {DATA_WIDTH{1'b0}};
    end else begin
      capture_data_s = bram_data_i;
    end
`endif
  end

  // Occupancy update; a capture and a pop in the same cycle cancel out.
  always_comb begin
    occ_next_s = occ_r;
    case ({capture_s, pop_s})
      2'b10:   occ_next_s = occ_r + CNT_W'(1);
      2'b01:   occ_next_s = occ_r - CNT_W'(1);
      default: occ_next_s = occ_r;
    endcase
  end

  // Control state: occupancy, in-flight flag and wrapping FIFO pointers.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      occ_r         <= {CNT_W{1'b0}};
      rd_inflight_r <= 1'b0;
      head_r        <= {PTR_W{1'b0}};
      tail_r        <= {PTR_W{1'b0}};
`ifdef BRAM_SP_REQ_ADAPTER_WRACK_EN
      wr_inflight_r <= 1'b0;
`endif
    end else begin
      occ_r         <= occ_next_s;
      rd_inflight_r <= alloc_s;
`ifdef BRAM_SP_REQ_ADAPTER_WRACK_EN
      wr_inflight_r <= fire_s & req_we_i;
`endif
      if (capture_s) begin
        tail_r <= tail_r + PTR_W'(1);
      end
      if (pop_s) begin
        head_r <= head_r + PTR_W'(1);
      end
    end
  end

  // Response storage: contents are don't-care after reset, so no reset term.
  always_ff @(posedge clk_i) begin
    if (capture_s) begin
      rsp_mem_r[tail_r] <= capture_data_s;
    end
  end

  // A capture into a full FIFO without a simultaneous pop would silently drop read data.
  a_no_overflow: assert property (@(posedge clk_i) disable iff (!rst_ni)
    !(capture_s && !pop_s && (occ_r == OCC_FULL)));

endmodule

// File: tb/tb_bram_sp_req_adapter.sv
// Scoreboard bench for bram_sp_req_adapter against a behavioural one-cycle-latency byte-masked BRAM.
// A second instance with RSP_DEPTH=4 is used for the full-rate streaming scenario.
`timescale 1ns/1ps
module tb_bram_sp_req_adapter;
  localparam int DW = 32;
  localparam int AW = 7;
  localparam int MW = 4;
`ifdef BRAM_SP_REQ_ADAPTER_WRACK_EN
  localparam bit WRACK = 1'b1;
`else
  localparam bit WRACK = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst_n;
  logic          mem_load;
  logic          req_valid, req_valid4, req_we, rsp_ready;
  logic [AW-1:0] req_addr;
  logic [DW-1:0] req_data;
  logic [MW-1:0] req_mask;

  logic          req_ready, rsp_valid, bram_we, bram_en;
  logic [DW-1:0] rsp_data, bram_wdata, bram_rdata;
  logic [AW-1:0] bram_addr;
  logic [MW-1:0] bram_mask;

  logic          req_ready4, rsp_valid4, bram_we4, bram_en4;
  logic [DW-1:0] rsp_data4, bram_wdata4, bram_rdata4;
  logic [AW-1:0] bram_addr4;
  logic [MW-1:0] bram_mask4;

  logic [DW-1:0] bram_mem  [1<<AW];
  logic [DW-1:0] bram_mem4 [1<<AW];
  logic [DW-1:0] ref_mem   [1<<AW];
  logic [DW-1:0] exp_q [$];
  logic [DW-1:0] exp_v;
  int n_vec = 0;
  int n_err = 0;
  int n_rsp = 0;

  always #5 clk = ~clk;

  bram_sp_req_adapter u_dut (
    .clk_i(clk), .rst_ni(rst_n),
    .req_valid_i(req_valid), .req_ready_o(req_ready), .req_we_i(req_we),
    .req_addr_i(req_addr), .req_data_i(req_data), .req_mask_i(req_mask),
    .rsp_valid_o(rsp_valid), .rsp_ready_i(rsp_ready), .rsp_data_o(rsp_data),
    .bram_data_o(bram_wdata), .bram_addr_o(bram_addr), .bram_mask_o(bram_mask),
    .bram_wr_en_o(bram_we), .bram_cmd_en_o(bram_en), .bram_data_i(bram_rdata)
  );

  bram_sp_req_adapter #(.RSP_DEPTH(4)) u_dut4 (
    .clk_i(clk), .rst_ni(rst_n),
    .req_valid_i(req_valid4), .req_ready_o(req_ready4), .req_we_i(req_we),
    .req_addr_i(req_addr), .req_data_i(req_data), .req_mask_i(req_mask),
    .rsp_valid_o(rsp_valid4), .rsp_ready_i(rsp_ready), .rsp_data_o(rsp_data4),
    .bram_data_o(bram_wdata4), .bram_addr_o(bram_addr4), .bram_mask_o(bram_mask4),
    .bram_wr_en_o(bram_we4), .bram_cmd_en_o(bram_en4), .bram_data_i(bram_rdata4)
  );

  function automatic logic [DW-1:0] init_val(input int i);
    return 32'hC0DE0000 + DW'(i);
  endfunction

  // Behavioural BRAMs: byte-masked write, registered read data.
  always @(posedge clk) begin
    if (mem_load) begin
      for (int i = 0; i < (1<<AW); i++) begin
        bram_mem[i]  <= init_val(i);
        bram_mem4[i] <= init_val(i);
      end
    end else begin
      if (bram_en) begin
        if (bram_we) begin
          for (int b = 0; b < MW; b++)
            if (bram_mask[b]) bram_mem[bram_addr][8*b +: 8] <= bram_wdata[8*b +: 8];
        end else begin
          bram_rdata <= bram_mem[bram_addr];
        end
      end
      if (bram_en4) begin
        if (bram_we4) begin
          for (int b = 0; b < MW; b++)
            if (bram_mask4[b]) bram_mem4[bram_addr4][8*b +: 8] <= bram_wdata4[8*b +: 8];
        end else begin
          bram_rdata4 <= bram_mem4[bram_addr4];
        end
      end
    end
  end

  // Scoreboard: push expected data on request handshake, compare on response handshake.
  always @(negedge clk) begin
    if (mem_load) begin
      for (int i = 0; i < (1<<AW); i++) ref_mem[i] = init_val(i);
    end else if (rst_n === 1'b1) begin
      if (rsp_valid === 1'b1 && rsp_ready === 1'b1) begin
        n_vec++;
        n_rsp++;
        if (exp_q.size() == 0) begin
          n_err++;
          $display("FAIL rsp_spurious: got %h, want no response", rsp_data);
        end else begin
          exp_v = exp_q.pop_front();
          if (rsp_data !== exp_v) begin
            n_err++;
            $display("FAIL rsp_data: got %h, want %h", rsp_data, exp_v);
          end
        end
      end
      if (req_valid === 1'b1 && req_ready === 1'b1) begin
        if (req_we) begin
          for (int b = 0; b < MW; b++)
            if (req_mask[b]) ref_mem[req_addr][8*b +: 8] = req_data[8*b +: 8];
          if (WRACK) exp_q.push_back({DW{1'b0}});
        end else begin
          exp_q.push_back(ref_mem[req_addr]);
        end
      end
    end
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic we, input logic [AW-1:0] a, input logic [DW-1:0] d,
                       input logic [MW-1:0] m);
    int w;
    req_valid = 1'b1; req_we = we; req_addr = a; req_data = d; req_mask = m;
    w = 0;
    while (req_ready !== 1'b1 && w < 20) begin
      tick;
      w++;
    end
    n_vec++;
    if (req_ready !== 1'b1) begin
      n_err++;
      $display("FAIL issue_accept: req_ready %b after %0d cycles, want 1", req_ready, w);
    end
    tick;
    req_valid = 1'b0;
  endtask

  task automatic drain;
    for (int w = 0; w < 40 && (exp_q.size() != 0 || rsp_valid === 1'b1); w++) tick;
    n_vec++;
    if (exp_q.size() != 0 || rsp_valid !== 1'b0) begin
      n_err++;
      $display("FAIL drain: pending %0d rsp_valid %b, want 0 and 0", exp_q.size(), rsp_valid);
    end
  endtask

  task automatic test_reset;
    req_valid = 1'b1; req_we = 1'b0; req_addr = 7'd3;
    #1;
    n_vec++; if (req_ready !== 1'b0) begin n_err++; $display("FAIL reset_ready: got %b want 0", req_ready); end
    n_vec++; if (bram_en !== 1'b0) begin n_err++; $display("FAIL reset_cmd_en: got %b want 0", bram_en); end
    tick;
    n_vec++; if (rsp_valid !== 1'b0) begin n_err++; $display("FAIL reset_rsp_valid: got %b want 0", rsp_valid); end
    rst_n = 1'b1; req_valid = 1'b0;
    #1;
    n_vec++; if (req_ready !== 1'b1) begin n_err++; $display("FAIL release_ready: got %b want 1", req_ready); end
    n_vec++; if (req_ready4 !== 1'b1) begin n_err++; $display("FAIL release_ready4: got %b want 1", req_ready4); end
    n_vec++; if (rsp_valid !== 1'b0) begin n_err++; $display("FAIL release_rsp_valid: got %b want 0", rsp_valid); end
    tick;
  endtask

  task automatic test_write_read;
    rsp_ready = 1'b1;
    req_valid = 1'b1; req_we = 1'b1; req_addr = 7'd5; req_data = 32'hDEADBEEF; req_mask = 4'hF;
    #1;
    n_vec++; if (bram_en !== 1'b1) begin n_err++; $display("FAIL wr_cmd_en: got %b want 1", bram_en); end
    n_vec++; if (bram_we !== 1'b1) begin n_err++; $display("FAIL wr_wr_en: got %b want 1", bram_we); end
    n_vec++; if (bram_addr !== 7'd5 || bram_wdata !== 32'hDEADBEEF || bram_mask !== 4'hF) begin
      n_err++; $display("FAIL wr_pins: got %h/%h/%h want 05/deadbeef/f", bram_addr, bram_wdata, bram_mask);
    end
    tick;
    req_we = 1'b0;
    #1;
    n_vec++; if (bram_en !== 1'b1) begin n_err++; $display("FAIL rd_cmd_en: got %b want 1", bram_en); end
    n_vec++; if (bram_we !== 1'b0) begin n_err++; $display("FAIL rd_wr_en: got %b want 0", bram_we); end
    tick;
    req_valid = 1'b0;
    n_vec++; if (rsp_valid !== WRACK) begin n_err++; $display("FAIL rd_lat1_valid: got %b want %b", rsp_valid, WRACK); end
    tick;
    n_vec++; if (rsp_valid !== 1'b1) begin n_err++; $display("FAIL rd_lat2_valid: got %b want 1", rsp_valid); end
    n_vec++; if (rsp_data !== 32'hDEADBEEF) begin n_err++; $display("FAIL rd_data: got %h want deadbeef", rsp_data); end
    tick;
    n_vec++; if (rsp_valid !== 1'b0) begin n_err++; $display("FAIL rd_lat3_valid: got %b want 0", rsp_valid); end
  endtask

  task automatic test_partial_write;
    rsp_ready = 1'b1;
    issue(1'b1, 7'd5, 32'h0000AA00, 4'b0010);
    issue(1'b0, 7'd5, 32'h0, 4'h0);
    tick;
    n_vec++; if (rsp_valid !== 1'b1 || rsp_data !== 32'hDEADAAEF) begin
      n_err++; $display("FAIL partial_data: got %b/%h want 1/deadaaef", rsp_valid, rsp_data);
    end
    drain;
  endtask

  task automatic test_backpressure;
    int idx, base, w;
    logic fired;
    rsp_ready = 1'b1;
    issue(1'b1, 7'd1, 32'h11, 4'hF);
    issue(1'b1, 7'd2, 32'h22, 4'hF);
    issue(1'b1, 7'd3, 32'h33, 4'hF);
    drain;
    base = n_rsp;
    rsp_ready = 1'b0;
    idx = 0; req_valid = 1'b1; req_we = 1'b0; req_mask = 4'h0;
    for (int c = 0; c < 6; c++) begin
      req_addr = AW'(1 + idx);
      fired = req_ready;
      tick;
      if (fired) idx++;
    end
    n_vec++; if (idx !== 2) begin n_err++; $display("FAIL bp_fires: got %0d want 2", idx); end
    n_vec++; if (req_ready !== 1'b0) begin n_err++; $display("FAIL bp_ready: got %b want 0", req_ready); end
    n_vec++; if (rsp_valid !== 1'b1 || rsp_data !== 32'h11) begin
      n_err++; $display("FAIL bp_head: got %b/%h want 1/00000011", rsp_valid, rsp_data);
    end
    rsp_ready = 1'b1;
    w = 0;
    while (idx < 3 && w < 20) begin
      req_addr = AW'(1 + idx);
      fired = req_ready;
      tick;
      if (fired) idx++;
      w++;
    end
    req_valid = 1'b0;
    n_vec++; if (idx !== 3) begin n_err++; $display("FAIL bp_third_fire: got %0d want 3", idx); end
    drain;
    n_vec++; if (n_rsp - base !== 3) begin n_err++; $display("FAIL bp_count: got %0d want 3", n_rsp - base); end
  endtask

  task automatic test_throughput;
    int rdy_miss, vcnt, dmiss;
    rdy_miss = 0; vcnt = 0; dmiss = 0;
    rsp_ready = 1'b1; req_we = 1'b0; req_mask = 4'h0;
    for (int c = 0; c < 18; c++) begin
      req_valid4 = (c < 16);
      req_addr = AW'((c < 16) ? c : 0);
      #1;
      if (c < 16 && req_ready4 !== 1'b1) rdy_miss++;
      if (c >= 2 && rsp_valid4 === 1'b1) begin
        vcnt++;
        if (rsp_data4 !== init_val(c - 2)) dmiss++;
      end
      tick;
    end
    req_valid4 = 1'b0;
    n_vec++; if (rdy_miss !== 0) begin n_err++; $display("FAIL tp_ready: %0d stalls, want 0", rdy_miss); end
    n_vec++; if (vcnt !== 16) begin n_err++; $display("FAIL tp_rsp_cycles: got %0d want 16", vcnt); end
    n_vec++; if (dmiss !== 0) begin n_err++; $display("FAIL tp_data: %0d bad beats, want 0", dmiss); end
    #1;
    n_vec++; if (rsp_valid4 !== 1'b0) begin n_err++; $display("FAIL tp_idle: got %b want 0", rsp_valid4); end
    tick;
  endtask

  task automatic test_reset_mid_read;
    int spur;
    spur = 0;
    rsp_ready = 1'b1;
    issue(1'b0, 7'd5, 32'h0, 4'h0);
    rst_n = 1'b0;
    #1;
    n_vec++; if (req_ready !== 1'b0) begin n_err++; $display("FAIL rst_mid_ready: got %b want 0", req_ready); end
    tick;
    rst_n = 1'b1;
    exp_q.delete();
    for (int c = 0; c < 6; c++) begin
      if (rsp_valid !== 1'b0) spur++;
      tick;
    end
    n_vec++; if (spur !== 0) begin n_err++; $display("FAIL rst_mid_spurious: %0d valid cycles, want 0", spur); end
    n_vec++; if (req_ready !== 1'b1) begin n_err++; $display("FAIL rst_mid_ready_after: got %b want 1", req_ready); end
    issue(1'b0, 7'd5, 32'h0, 4'h0);
    drain;
  endtask

`ifdef BRAM_SP_REQ_ADAPTER_WRACK_EN
  task automatic test_wrack;
    int base;
    rsp_ready = 1'b1;
    base = n_rsp;
    issue(1'b1, 7'd9, 32'h12345678, 4'hF);
    issue(1'b0, 7'd9, 32'h0, 4'h0);
    n_vec++; if (rsp_valid !== 1'b1 || rsp_data !== 32'h0) begin
      n_err++; $display("FAIL wrack_ack: got %b/%h want 1/00000000", rsp_valid, rsp_data);
    end
    tick;
    n_vec++; if (rsp_valid !== 1'b1 || rsp_data !== 32'h12345678) begin
      n_err++; $display("FAIL wrack_read: got %b/%h want 1/12345678", rsp_valid, rsp_data);
    end
    drain;
    n_vec++; if (n_rsp - base !== 2) begin n_err++; $display("FAIL wrack_count: got %0d want 2", n_rsp - base); end
  endtask
`endif

  initial begin
    rst_n = 1'b0; mem_load = 1'b1;
    req_valid = 1'b0; req_valid4 = 1'b0; req_we = 1'b0;
    req_addr = {AW{1'b0}}; req_data = {DW{1'b0}}; req_mask = {MW{1'b0}}; rsp_ready = 1'b0;
    tick;
    tick;
    mem_load = 1'b0;
    test_reset;
    test_write_read;
    test_partial_write;
    test_backpressure;
    test_throughput;
    test_reset_mid_read;
`ifdef BRAM_SP_REQ_ADAPTER_WRACK_EN
    test_wrack;
`endif
    drain;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
